// File: rtl/fetch_decode_queue.sv
// Small FIFO decoupling fetch_unit from decode: captures (pc, instr) each cycle,
// presents the head with valid/ready, and holds fetch via keep when full.
//
// state | meaning
// BOOT  | fetch is loading the reset vector; nothing captured, nothing presented
// RUN   | normal capture/drain; left only through reset
module fetch_decode_queue #(
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic          clk,
    input  logic          rst_signal,
    input  logic [31:0]   fetch_pc,
    input  logic [31:0]   fetch_instr,
    input  logic          fetch_extend,
    input  logic          flush,
    output logic          keep,
    input  logic          dec_ready,
    output logic          dec_valid,
    output logic [31:0]   dec_pc,
    output logic [31:0]   dec_pc4,
    output logic [31:0]   dec_instr,
    output logic [AW:0]   count
);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [31:0]   mem_pc    [DEPTH];
    logic [31:0]   mem_instr [DEPTH];
    logic          full;
    logic          next_run;
    logic          push;
    logic          pop;

    always_ff @(posedge clk or negedge rst_signal) begin
        if (!rst_signal) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        next_run   = 1'b0;
        keep       = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        case (state)
            BOOT: begin
                if (!fetch_extend) begin
                    state_next = RUN;
                    next_run   = 1'b1;
                end
            end
            RUN: begin
                next_run = 1'b1;
                keep     = full && !fetch_extend;
                pop      = dec_valid && dec_ready && !flush;
            end
            default: state_next = BOOT;
        endcase
        // A full queue refuses the word even when popping; fetch re-presents it.
        push = next_run && !fetch_extend && !flush && !full;
    end

    assign full = (count == DEPTH_C);

    always_ff @(posedge clk or negedge rst_signal) begin
        if (!rst_signal) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_signal) begin
        if (!rst_signal) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_pc[i]    <= '0;
                mem_instr[i] <= '0;
            end
        end else if (push) begin
            mem_pc[wr_ptr]    <= fetch_pc;
            mem_instr[wr_ptr] <= fetch_instr;
        end
    end

    assign dec_valid = (state == RUN) && (count != '0);
    assign dec_pc    = mem_pc[rd_ptr];
    assign dec_pc4   = dec_pc + 32'd4;
    assign dec_instr = dec_valid ? mem_instr[rd_ptr] : 32'h0000_0000;

endmodule
